// File: rtl/pc_ir_unit.sv
// rtl/pc_ir_unit.sv - program counter, instruction register and memory address mux.
// Optional taken-branch PC trace buffer enabled by defining PC_TRACE_EN.
module pc_ir_unit #(
    parameter int DW    = 16,
    parameter int OFS_W = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pc_ld,
    input  logic          pc_inc,
    input  logic          pc_sel,
    input  logic          ir_ld,
    input  logic          adr_sel,
    input  logic [DW-1:0] mem_dout,
    input  logic [DW-1:0] r_data,
    output logic [DW-1:0] ir,
    output logic [DW-1:0] pc,
    output logic [DW-1:0] mem_adr
`ifdef PC_TRACE_EN
    ,
    input  logic [1:0]    trace_idx,
    output logic [DW-1:0] trace_pc,
    output logic [2:0]    trace_cnt
`endif
);

    logic [DW-1:0] pc_q, pc_d;
    logic [DW-1:0] ir_q, ir_d;
    logic [DW-1:0] ofs_ext;

    // Offset always comes from the pre-edge IR, even when IR reloads in the same cycle.
    assign ofs_ext = {{(DW-OFS_W){ir_q[OFS_W-1]}}, ir_q[OFS_W-1:0]};

    always_comb begin
        pc_d = pc_q;
        if (pc_ld) begin
            if (pc_sel) pc_d = r_data;
            else        pc_d = pc_q + ofs_ext;
        end else if (pc_inc) begin
            pc_d = pc_q + {{(DW-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        ir_d = ir_q;
        if (ir_ld) ir_d = mem_dout;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= '0;
            ir_q <= '0;
        end else begin
            pc_q <= pc_d;
            ir_q <= ir_d;
        end
    end

    assign pc      = pc_q;
    assign ir      = ir_q;
    assign mem_adr = adr_sel ? r_data : pc_q;

`ifdef PC_TRACE_EN
    logic [DW-1:0] trace_buf_q [4];
    logic [DW-1:0] trace_buf_d [4];
    logic [1:0]    trace_wr_q, trace_wr_d;
    logic [2:0]    trace_cnt_q, trace_cnt_d;
    logic [1:0]    trace_rd_ptr;

    always_comb begin
        trace_buf_d = trace_buf_q;
        trace_wr_d  = trace_wr_q;
        trace_cnt_d = trace_cnt_q;
        if (pc_ld) begin
            trace_buf_d[trace_wr_q] = pc_q;
            trace_wr_d              = trace_wr_q + 2'd1;
            if (trace_cnt_q != 3'd4) trace_cnt_d = trace_cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) trace_buf_q[i] <= '0;
            trace_wr_q  <= '0;
            trace_cnt_q <= '0;
        end else begin
            trace_buf_q <= trace_buf_d;
            trace_wr_q  <= trace_wr_d;
            trace_cnt_q <= trace_cnt_d;
        end
    end

    // Write pointer sits one past the newest entry; wrap-around is free in two bits.
    assign trace_rd_ptr = trace_wr_q - 2'd1 - trace_idx;
    assign trace_pc     = ({1'b0, trace_idx} < trace_cnt_q) ? trace_buf_q[trace_rd_ptr] : '0;
    assign trace_cnt    = trace_cnt_q;
`endif

endmodule

// File: tb/tb_pc_ir_unit.sv
// tb/tb_pc_ir_unit.sv - self-checking bench for pc_ir_unit with a behavioural reference model.
module tb_pc_ir_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pc_ld = 1'b0, pc_inc = 1'b0, pc_sel = 1'b0, ir_ld = 1'b0, adr_sel = 1'b0;
    logic [15:0] mem_dout, r_data = 16'h0;
    logic [15:0] ir, pc, mem_adr;
    logic [1:0]  trace_idx = 2'd0;
    logic [15:0] trace_pc;
    logic [2:0]  trace_cnt;

    logic [15:0] mem [256];
    assign mem_dout = mem[mem_adr[7:0]];

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] pc_m = 16'h0;
    logic [15:0] ir_m = 16'h0;
    logic [15:0] trace_m [$];

    always #5 clk = ~clk;

    pc_ir_unit #(.DW(16), .OFS_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .pc_ld    (pc_ld),
        .pc_inc   (pc_inc),
        .pc_sel   (pc_sel),
        .ir_ld    (ir_ld),
        .adr_sel  (adr_sel),
        .mem_dout (mem_dout),
        .r_data   (r_data),
        .ir       (ir),
        .pc       (pc),
        .mem_adr  (mem_adr)
`ifdef PC_TRACE_EN
        ,
        .trace_idx(trace_idx),
        .trace_pc (trace_pc),
        .trace_cnt(trace_cnt)
`endif
    );

`ifndef PC_TRACE_EN
    assign trace_pc  = 16'h0;
    assign trace_cnt = 3'd0;
`endif

    function automatic logic [15:0] trace_exp(input int idx);
        return (idx < trace_m.size()) ? trace_m[idx] : 16'h0000;
    endfunction

    task automatic drive(input logic ld, input logic inc, input logic sel,
                         input logic irl, input logic asel, input logic [15:0] rd);
        pc_ld = ld; pc_inc = inc; pc_sel = sel; ir_ld = irl; adr_sel = asel; r_data = rd;
    endtask

    // Advance one clock; the model is computed from the rules before the edge.
    task automatic tick();
        logic [15:0] adr, nxt_pc, nxt_ir;
        int off;
        adr    = adr_sel ? r_data : pc_m;
        nxt_ir = ir_ld ? mem[adr[7:0]] : ir_m;
        off    = int'($signed(ir_m[7:0]));
        if (pc_ld) nxt_pc = pc_sel ? r_data : 16'(int'(pc_m) + off);
        else if (pc_inc) nxt_pc = 16'(int'(pc_m) + 1);
        else nxt_pc = pc_m;
        if (pc_ld) begin
            trace_m.push_front(pc_m);
            if (trace_m.size() > 4) void'(trace_m.pop_back());
        end
        @(posedge clk);
        #1;
        pc_m = nxt_pc;
        ir_m = nxt_ir;
    endtask

    task automatic set_state(input logic [15:0] p, input logic [15:0] i);
        mem[p[7:0]] = i;
        drive(1, 0, 1, 1, 1, p);
        tick();
        drive(0, 0, 0, 0, 0, 16'h0);
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 16'h0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        pc_m = 16'h0; ir_m = 16'h0; trace_m.delete();
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 16'h0);
        #12;
        vectors++; if (pc !== 16'h0000) begin miscompares++; $display("FAIL reset_pc got %h exp 0000", pc); end
        vectors++; if (ir !== 16'h0000) begin miscompares++; $display("FAIL reset_ir got %h exp 0000", ir); end
        vectors++; if (mem_adr !== 16'h0000) begin miscompares++; $display("FAIL reset_adr got %h exp 0000", mem_adr); end
`ifdef PC_TRACE_EN
        vectors++; if (trace_cnt !== 3'd0) begin miscompares++; $display("FAIL reset_tcnt got %0d exp 0", trace_cnt); end
        vectors++; if (trace_pc !== 16'h0000) begin miscompares++; $display("FAIL reset_tpc got %h exp 0000", trace_pc); end
`endif
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_fetch();
        logic [15:0] prog [3];
        prog = '{16'hE001, 16'hE202, 16'hF600};
        for (int i = 0; i < 3; i++) mem[i] = prog[i];
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 1, 0, 16'h0);
            #1;
            vectors++; if (mem_adr !== 16'(i)) begin miscompares++; $display("FAIL fetch_adr%0d got %h exp %h", i, mem_adr, 16'(i)); end
            tick();
            vectors++; if (pc !== 16'(i + 1)) begin miscompares++; $display("FAIL fetch_pc%0d got %h exp %h", i, pc, 16'(i + 1)); end
            vectors++; if (ir !== prog[i]) begin miscompares++; $display("FAIL fetch_ir%0d got %h exp %h", i, ir, prog[i]); end
        end
    endtask

    task automatic test_branch();
        set_state(16'h0010, 16'hF8FC);
        drive(1, 0, 0, 0, 0, 16'h0); tick();
        vectors++; if (pc !== 16'h000C) begin miscompares++; $display("FAIL branch_back got %h exp 000c", pc); end
        set_state(16'h0010, 16'hF805);
        drive(1, 0, 0, 0, 0, 16'h0); tick();
        vectors++; if (pc !== 16'h0015) begin miscompares++; $display("FAIL branch_fwd got %h exp 0015", pc); end
        // IR reload in the branch cycle must not affect the offset used.
        set_state(16'h0020, 16'h0003);
        mem[8'h20] = 16'h00F0;
        drive(1, 0, 0, 1, 0, 16'h0); tick();
        vectors++; if (pc !== 16'h0023) begin miscompares++; $display("FAIL branch_oldir_pc got %h exp 0023", pc); end
        vectors++; if (ir !== 16'h00F0) begin miscompares++; $display("FAIL branch_oldir_ir got %h exp 00f0", ir); end
    endtask

    task automatic test_priority();
        drive(1, 1, 1, 0, 1, 16'h0042);
        #1;
        vectors++; if (mem_adr !== 16'h0042) begin miscompares++; $display("FAIL prio_adr got %h exp 0042", mem_adr); end
        tick();
        vectors++; if (pc !== 16'h0042) begin miscompares++; $display("FAIL prio_pc got %h exp 0042", pc); end
    endtask

    task automatic test_wrap();
        set_state(16'hFFFF, 16'h0000);
        drive(0, 1, 0, 0, 0, 16'h0); tick();
        vectors++; if (pc !== 16'h0000) begin miscompares++; $display("FAIL wrap_inc got %h exp 0000", pc); end
        set_state(16'h0001, 16'h00FD);
        drive(1, 0, 0, 0, 0, 16'h0); tick();
        vectors++; if (pc !== 16'hFFFE) begin miscompares++; $display("FAIL wrap_branch got %h exp fffe", pc); end
    endtask

    task automatic test_reset_mid();
        set_state(16'h0055, 16'h1234);
        drive(1, 1, 1, 1, 0, 16'h00AA);
        #3;
        reset = 1'b1;
        #1;
        vectors++; if (pc !== 16'h0000) begin miscompares++; $display("FAIL rstmid_pc got %h exp 0000", pc); end
        vectors++; if (ir !== 16'h0000) begin miscompares++; $display("FAIL rstmid_ir got %h exp 0000", ir); end
        vectors++; if (trace_cnt !== 3'd0) begin miscompares++; $display("FAIL rstmid_tcnt got %0d exp 0", trace_cnt); end
        @(posedge clk);
        #1;
        vectors++; if (pc !== 16'h0000) begin miscompares++; $display("FAIL rsthold_pc got %h exp 0000", pc); end
        vectors++; if (ir !== 16'h0000) begin miscompares++; $display("FAIL rsthold_ir got %h exp 0000", ir); end
        drive(0, 0, 0, 0, 0, 16'h0);
        reset = 1'b0;
        pc_m = 16'h0; ir_m = 16'h0; trace_m.delete();
    endtask

`ifdef PC_TRACE_EN
    task automatic test_trace();
        logic [15:0] exp4 [4];
        exp4 = '{16'h0050, 16'h0040, 16'h0030, 16'h0020};
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            drive(1, 0, 1, 0, 0, 16'(k * 16)); tick();
        end
        drive(0, 0, 0, 0, 0, 16'h0);
        vectors++; if (trace_cnt !== 3'd4) begin miscompares++; $display("FAIL trace_cnt got %0d exp 4", trace_cnt); end
        for (int i = 0; i < 4; i++) begin
            trace_idx = 2'(i);
            #1;
            vectors++; if (trace_pc !== exp4[i]) begin miscompares++; $display("FAIL trace_idx%0d got %h exp %h", i, trace_pc, exp4[i]); end
        end
        do_reset();
        trace_idx = 2'd0;
        #1;
        vectors++; if (trace_pc !== 16'h0000) begin miscompares++; $display("FAIL trace_rst got %h exp 0000", trace_pc); end
        drive(1, 0, 1, 0, 0, 16'h0033); tick();
        drive(0, 0, 0, 0, 0, 16'h0);
        trace_idx = 2'd1;
        #1;
        vectors++; if (trace_pc !== 16'h0000) begin miscompares++; $display("FAIL trace_beyond got %h exp 0000", trace_pc); end
        vectors++; if (trace_cnt !== 3'd1) begin miscompares++; $display("FAIL trace_cnt1 got %0d exp 1", trace_cnt); end
    endtask
`endif

    task automatic test_random();
        logic [15:0] exp_adr;
        for (int a = 0; a < 256; a++) mem[a] = 16'($urandom);
        for (int n = 0; n < 300; n++) begin
            drive(($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), 16'($urandom));
            trace_idx = 2'($urandom);
            #1;
            exp_adr = adr_sel ? r_data : pc_m;
            vectors++; if (mem_adr !== exp_adr) begin miscompares++; $display("FAIL rnd_adr%0d got %h exp %h", n, mem_adr, exp_adr); end
            tick();
            vectors++; if (pc !== pc_m) begin miscompares++; $display("FAIL rnd_pc%0d got %h exp %h", n, pc, pc_m); end
            vectors++; if (ir !== ir_m) begin miscompares++; $display("FAIL rnd_ir%0d got %h exp %h", n, ir, ir_m); end
`ifdef PC_TRACE_EN
            vectors++; if (trace_cnt !== 3'(trace_m.size())) begin miscompares++; $display("FAIL rnd_tcnt%0d got %0d exp %0d", n, trace_cnt, trace_m.size()); end
            vectors++; if (trace_pc !== trace_exp(int'(trace_idx))) begin miscompares++; $display("FAIL rnd_tpc%0d got %h exp %h", n, trace_pc, trace_exp(int'(trace_idx))); end
`endif
        end
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 16'h0;
        test_reset();
        test_fetch();
        test_branch();
        test_priority();
        test_wrap();
        test_reset_mid();
`ifdef PC_TRACE_EN
        test_trace();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
